// File: rtl/adc_serial_sampler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared types and default parameter values for the multi-channel
//            serial-ADC capture engine (adc_serial_sampler and adc_lane).
// Contents : state_t       - capture FSM state encoding
//            c_DEF_*       - default parameter values
//            cnt_width()   - counter width helper (never returns 0)
// Revision : 1.0  initial release
// ============================================================================
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        QUIET = 2'd2
    } state_t;

    localparam int c_DEF_CLK_DIV    = 2;
    localparam int c_DEF_FRAME_BITS = 16;
    localparam int c_DEF_DATA_BITS  = 12;
    localparam int c_DEF_NUM_CH     = 2;
    localparam int c_DEF_QUIET_CYC  = 4;
    localparam int c_DEF_AVG_LOG2   = 0;

    // Bits needed for a counter that takes n_values distinct values
    // (0 .. n_values-1). Clamped to 1 so single-value counters still
    // elaborate as a real register.
    function automatic int cnt_width(input int n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_serial_sampler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_serial_sampler_if
// Purpose  : Result handshake bundle between the capture engine and its
//            consumer (formatter, logger).
// Signals  : sample_data   result word, channel i at [i*DATA_BITS +: DATA_BITS]
//            sample_valid  result available (producer -> consumer)
//            sample_ready  consumer accepts (consumer -> producer)
// Modports : master = producer side, slave = consumer side
// Revision : 1.0  initial release
// ============================================================================
interface adc_serial_sampler_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/adc_serial_sampler_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_lane
// Purpose  : One ADC channel: MSB-first frame shift register, unsigned
//            averaging accumulator and truncated result register.
// Ports    : clk, rst_n      clock, asynchronous active-low reset
//            i_sdata         serial data bit from this channel's ADC
//            i_shift         shift i_sdata in (sclk rising edge)
//            i_frame_end     last cycle of the frame: accumulate
//            i_group_done    this frame completes the averaging group
//            o_result        averaged result of the last completed group
// Revision : 1.0  initial release
// ============================================================================
module adc_lane
    import adc_pkg::*;
#(
    parameter int FRAME_BITS = c_DEF_FRAME_BITS,
    parameter int DATA_BITS  = c_DEF_DATA_BITS,
    parameter int AVG_LOG2   = c_DEF_AVG_LOG2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sdata,
    input  logic                 i_shift,
    input  logic                 i_frame_end,
    input  logic                 i_group_done,
    output logic [DATA_BITS-1:0] o_result
);

    localparam int c_ACC_W = DATA_BITS + AVG_LOG2;

    logic [FRAME_BITS-1:0] r_shift;
    logic [c_ACC_W-1:0]    r_acc;
    logic [DATA_BITS-1:0]  r_result;
    logic [c_ACC_W-1:0]    w_sum;
    logic [DATA_BITS-1:0]  w_avg;

    // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples,
    // so this sum cannot overflow within a group.
    assign w_sum = r_acc + c_ACC_W'(r_shift[DATA_BITS-1:0]);
    assign w_avg = DATA_BITS'(w_sum >> AVG_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (i_shift) begin
            r_shift <= (r_shift << 1) | FRAME_BITS'(i_sdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_result <= '0;
        end else if (i_frame_end) begin
            if (i_group_done) begin
                r_result <= w_avg;
                r_acc    <= '0;
            end else begin
                r_acc    <= w_sum;
            end
        end
    end

    assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/adc_serial_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_serial_sampler
// Purpose  : Drives a shared sclk/cs pair to NUM_CH serial ADCs, deserialises
//            one frame per conversion, optionally averages 2^AVG_LOG2
//            conversions and offers the result over a valid/ready handshake.
// Ports    : clk, rst_n      clock, asynchronous active-low reset
//            sdata[NUM_CH]   serial data, bit i from ADC i
//            mode_cont       1 = continuous conversions, 0 = single-shot
//            start           single-shot trigger (IDLE and mode_cont=0 only)
//            sclk, cs        ADC serial clock (idles high), chip select (low)
//            smp             result handshake (master side)
//            overrun         sticky: a result was dropped
//            clr_ovr         synchronous clear of overrun
//            busy            FSM not in IDLE
// Revision : 1.0  initial release
// ============================================================================
module adc_serial_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = c_DEF_CLK_DIV,
    parameter int FRAME_BITS = c_DEF_FRAME_BITS,
    parameter int DATA_BITS  = c_DEF_DATA_BITS,
    parameter int NUM_CH     = c_DEF_NUM_CH,
    parameter int QUIET_CYC  = c_DEF_QUIET_CYC,
    parameter int AVG_LOG2   = c_DEF_AVG_LOG2
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  sdata,
    input  logic               mode_cont,
    input  logic               start,
    output logic               sclk,
    output logic               cs,
    adc_serial_sampler_if.master smp,
    output logic               overrun,
    input  logic               clr_ovr,
    output logic               busy
);

    // A frame is 2*FRAME_BITS+1 sclk half-periods: one leading high half,
    // then FRAME_BITS low/high pairs. The last high half doubles as the
    // hold time between the final rising edge and cs rising.
    localparam int c_LAST_HALF = 2 * FRAME_BITS;
    localparam int c_DIV_W     = cnt_width(CLK_DIV);
    localparam int c_HALF_W    = cnt_width(c_LAST_HALF + 1);
    localparam int c_Q_W       = cnt_width(QUIET_CYC);
    localparam int c_AVG_W     = AVG_LOG2 + 1;
    localparam int c_RES_W     = NUM_CH * DATA_BITS;

    state_t                r_state;
    state_t                w_next;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_HALF_W-1:0]   r_half;
    logic [c_Q_W-1:0]      r_quiet;
    logic [c_AVG_W-1:0]    r_avg_cnt;
    logic                  r_sclk;
    logic                  r_cs;
    logic                  r_res_stb;
    logic                  r_valid;
    logic [c_RES_W-1:0]    r_data;
    logic                  r_ovr;

    logic                  w_div_wrap;
    logic                  w_frame_end;
    logic                  w_quiet_end;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_group_done;
    logic                  w_avg_pending;
    logic                  w_enter_frame;
    logic [c_RES_W-1:0]    w_results;

    // ------------------------------------------------------------------
    // Timing strobes derived from the divider and half-period counters
    // ------------------------------------------------------------------
    assign w_div_wrap    = (r_div == c_DIV_W'(CLK_DIV - 1));
    assign w_frame_end   = (r_state == FRAME) && w_div_wrap &&
                           (r_half == c_HALF_W'(c_LAST_HALF));
    assign w_quiet_end   = (r_state == QUIET) &&
                           (r_quiet == c_Q_W'(QUIET_CYC - 1));
    // Leaving an odd (low) half means sclk rises; leaving an even half
    // other than the last one means sclk falls.
    assign w_rise        = (r_state == FRAME) && w_div_wrap && !w_frame_end &&  r_half[0];
    assign w_fall        = (r_state == FRAME) && w_div_wrap && !w_frame_end && !r_half[0];
    assign w_group_done  = w_frame_end &&
                           (r_avg_cnt == c_AVG_W'((1 << AVG_LOG2) - 1));
    assign w_avg_pending = (r_avg_cnt != '0);
    assign w_enter_frame = (w_next == FRAME) && (r_state != FRAME);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mode_cont || start) begin
                    w_next = FRAME;
                end
            end
            FRAME: begin
                if (w_frame_end) begin
                    w_next = QUIET;
                end
            end
            QUIET: begin
                // An unfinished averaging group always runs to completion,
                // even after mode_cont drops.
                if (w_quiet_end) begin
                    w_next = (mode_cont || w_avg_pending) ? FRAME : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Clock divider, half-period and quiet counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_half <= '0;
        end else if (w_enter_frame) begin
            r_div  <= '0;
            r_half <= '0;
        end else if (r_state == FRAME) begin
            if (w_div_wrap) begin
                r_div  <= '0;
                r_half <= r_half + 1'b1;
            end else begin
                r_div  <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quiet <= '0;
        end else if (r_state != QUIET) begin
            r_quiet <= '0;
        end else begin
            r_quiet <= r_quiet + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ADC pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs   <= 1'b1;
            r_sclk <= 1'b1;
        end else begin
            if (w_enter_frame) begin
                r_cs <= 1'b0;
            end else if (w_frame_end) begin
                r_cs <= 1'b1;
            end

            if (w_fall) begin
                r_sclk <= 1'b0;
            end else if (w_rise || w_enter_frame || w_frame_end) begin
                r_sclk <= 1'b1;
            end
        end
    end

    assign sclk = r_sclk;
    assign cs   = r_cs;
    assign busy = (r_state != IDLE);

    // ------------------------------------------------------------------
    // Averaging counter; r_res_stb marks the cycle after a group completes,
    // when the lane result registers hold the fresh average.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg_cnt <= '0;
            r_res_stb <= 1'b0;
        end else begin
            r_res_stb <= w_group_done;
            if (w_group_done) begin
                r_avg_cnt <= '0;
            end else if (w_frame_end) begin
                r_avg_cnt <= r_avg_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel lanes
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        adc_lane #(
            .FRAME_BITS (FRAME_BITS),
            .DATA_BITS  (DATA_BITS),
            .AVG_LOG2   (AVG_LOG2)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_sdata      (sdata[gi]),
            .i_shift      (w_rise),
            .i_frame_end  (w_frame_end),
            .i_group_done (w_group_done),
            .o_result     (w_results[gi*DATA_BITS +: DATA_BITS])
        );
    end

    // ------------------------------------------------------------------
    // Output handshake register. A new result replaces the held one only
    // if the held one is consumed in the same cycle; otherwise it is
    // dropped and overrun latches (set beats clear).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (r_res_stb && (!r_valid || smp.sample_ready)) begin
            r_valid <= 1'b1;
            r_data  <= w_results;
        end else if (r_valid && smp.sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (r_res_stb && r_valid && !smp.sample_ready) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign smp.sample_valid = r_valid;
    assign smp.sample_data  = r_data;
    assign overrun          = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_serial_sampler
// Purpose  : Scoreboard bench for adc_serial_sampler. Three instances:
//            u_dut0 (defaults), u_dutA (AVG_LOG2=2), u_dutF (CLK_DIV=1,
//            NUM_CH=1). Each has a behavioural ADC model that shifts a queued
//            frame out MSB-first on sclk falling edges.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_serial_sampler;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT instances ----------------
    logic [1:0] sdata0;
    logic       mode0, start0, sclk0, cs0, ovr0, clr0, busy0;
    adc_serial_sampler_if #(.DATA_W(24)) if0 ();
    adc_serial_sampler u_dut0 (
        .clk(clk), .rst_n(rst_n), .sdata(sdata0), .mode_cont(mode0),
        .start(start0), .sclk(sclk0), .cs(cs0), .smp(if0), .overrun(ovr0),
        .clr_ovr(clr0), .busy(busy0)
    );

    logic [1:0] sdataA;
    logic       modeA, startA, sclkA, csA, ovrA, clrA, busyA;
    adc_serial_sampler_if #(.DATA_W(24)) ifA ();
    adc_serial_sampler #(.AVG_LOG2(2)) u_dutA (
        .clk(clk), .rst_n(rst_n), .sdata(sdataA), .mode_cont(modeA),
        .start(startA), .sclk(sclkA), .cs(csA), .smp(ifA), .overrun(ovrA),
        .clr_ovr(clrA), .busy(busyA)
    );

    logic [0:0] sdataF;
    logic       modeF, startF, sclkF, csF, ovrF, clrF, busyF;
    adc_serial_sampler_if #(.DATA_W(12)) ifF ();
    adc_serial_sampler #(.CLK_DIV(1), .NUM_CH(1)) u_dutF (
        .clk(clk), .rst_n(rst_n), .sdata(sdataF), .mode_cont(modeF),
        .start(startF), .sclk(sclkF), .cs(csF), .smp(ifF), .overrun(ovrF),
        .clr_ovr(clrF), .busy(busyF)
    );

    // ---------------- ADC models: frame = {ch1[15:0], ch0[15:0]} ----------------
    logic [31:0] f0_q[$], fA_q[$];
    logic [15:0] fF_q[$];
    logic [31:0] f0_cur, fA_cur;
    logic [15:0] fF_cur;
    int          f0_idx, fA_idx, fF_idx;
    int          nfA = 0, nfF = 0;

    always @(negedge cs0) begin
        f0_cur <= (f0_q.size() != 0) ? f0_q[0] : 32'h0;
        if (f0_q.size() != 0) f0_q.pop_front();
        f0_idx <= 15;
    end
    always @(negedge sclk0) if (!cs0 && f0_idx >= 0) begin
        sdata0 <= {f0_cur[16 + f0_idx], f0_cur[f0_idx]};
        f0_idx <= f0_idx - 1;
    end

    always @(negedge csA) begin
        fA_cur <= (fA_q.size() != 0) ? fA_q[0] : 32'h0;
        if (fA_q.size() != 0) fA_q.pop_front();
        fA_idx <= 15;
        nfA    <= nfA + 1;
    end
    always @(negedge sclkA) if (!csA && fA_idx >= 0) begin
        sdataA <= {fA_cur[16 + fA_idx], fA_cur[fA_idx]};
        fA_idx <= fA_idx - 1;
    end

    always @(negedge csF) begin
        fF_cur <= (fF_q.size() != 0) ? fF_q[0] : 16'h0;
        if (fF_q.size() != 0) fF_q.pop_front();
        fF_idx <= 15;
        nfF    <= nfF + 1;
    end
    always @(negedge sclkF) if (!csF && fF_idx >= 0) begin
        sdataF <= fF_cur[fF_idx];
        fF_idx <= fF_idx - 1;
    end

    // ---------------- Check helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return cs0;
            1:       return if0.sample_valid;
            2:       return busy0;
            3:       return busyA;
            4:       return csF;
            5:       return sclk0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_lvl(input string nm, input int sel, input logic lvl,
                            input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (sig(sel) === lvl) begin
                t = cyc;
                return;
            end
        end
        fail_now(nm, "timeout waiting for signal level");
    endtask

    // ---------------- Scoreboards / monitors ----------------
    logic [23:0] exp0[$], expA[$];
    logic [11:0] expF[$];
    int          acc0 = 0, accA = 0, accF = 0;

    always @(negedge clk) if (rst_n && if0.sample_valid && if0.sample_ready) begin
        acc0 <= acc0 + 1;
        if (exp0.size() == 0) fail_now("sb0_extra", "result with nothing expected");
        else chk("sb0_data", 32'(if0.sample_data), 32'(exp0.pop_front()));
    end

    always @(negedge clk) if (rst_n && ifA.sample_valid && ifA.sample_ready) begin
        accA <= accA + 1;
        if (expA.size() == 0) fail_now("sbA_extra", "result with nothing expected");
        else chk("sbA_data", 32'(ifA.sample_data), 32'(expA.pop_front()));
    end

    always @(negedge clk) if (rst_n && ifF.sample_valid && ifF.sample_ready) begin
        accF <= accF + 1;
        if (expF.size() == 0) fail_now("sbF_extra", "result with nothing expected");
        else chk("sbF_data", 32'(ifF.sample_data), 32'(expF.pop_front()));
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        int ts, t0, t1, t2, t3, ncs;
        int tv[3];

        rst_n = 1'b0;
        {mode0, start0, clr0, modeA, startA, clrA, modeF, startF, clrF} = '0;
        sdata0 = '0; sdataA = '0; sdataF = '0;
        if0.sample_ready = 1'b1;
        ifA.sample_ready = 1'b1;
        ifF.sample_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sclk",  32'(sclk0), 1);
        chk("rst_cs",    32'(cs0), 1);
        chk("rst_valid", 32'(if0.sample_valid), 0);
        chk("rst_data",  32'(if0.sample_data), 0);
        chk("rst_ovr",   32'(ovr0), 0);
        chk("rst_busy",  32'(busy0), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-shot
        f0_q.push_back(32'h0123_0ABC);
        exp0.push_back({12'h123, 12'hABC});
        ts = cyc;
        start0 = 1'b1;
        wait_lvl("ss_cs_fall", 0, 1'b0, 5, t0);
        start0 = 1'b0;
        chk("ss_cs_fall_cycle", 32'(t0 - ts), 1);
        wait_lvl("ss_sclk_fall", 5, 1'b0, 10, t1);
        chk("ss_sclk_fall_cycle", 32'(t1 - ts), 3);
        wait_lvl("ss_cs_rise", 0, 1'b1, 200, t1);
        chk("ss_cs_low_len", 32'(t1 - t0), 66);
        wait_lvl("ss_valid", 1, 1'b1, 10, t2);
        chk("ss_valid_lat", 32'(t2 - t1), 1);
        wait_lvl("ss_idle", 2, 1'b0, 20, t3);
        chk("ss_busy_drop", 32'(t3 - t1), 4);
        chk("ss_ovr", 32'(ovr0), 0);

        // Continuous, always ready
        f0_q.push_back(32'h00AA_0100);
        f0_q.push_back(32'h00BB_0200);
        f0_q.push_back(32'h00CC_0300);
        exp0.push_back({12'h0AA, 12'h100});
        exp0.push_back({12'h0BB, 12'h200});
        exp0.push_back({12'h0CC, 12'h300});
        mode0 = 1'b1;
        wait_lvl("ct_valid0", 1, 1'b1, 200, tv[0]);
        wait_lvl("ct_valid1", 1, 1'b1, 200, tv[1]);
        wait_lvl("ct_cs3", 0, 1'b0, 20, t0);
        mode0 = 1'b0;
        wait_lvl("ct_valid2", 1, 1'b1, 200, tv[2]);
        chk("ct_period01", 32'(tv[1] - tv[0]), 70);
        chk("ct_period12", 32'(tv[2] - tv[1]), 70);
        wait_lvl("ct_idle", 2, 1'b0, 20, t3);
        chk("ct_ovr", 32'(ovr0), 0);
        chk("ct_all_seen", 32'(exp0.size()), 0);

        // Backpressure
        @(posedge clk); #1 if0.sample_ready = 1'b0;
        f0_q.push_back(32'h0333_0111);
        f0_q.push_back(32'h0444_0222);
        exp0.push_back({12'h333, 12'h111});
        @(negedge clk);
        mode0 = 1'b1;
        wait_lvl("bp_cs1", 0, 1'b0, 10, t0);
        wait_lvl("bp_cs1_hi", 0, 1'b1, 200, t0);
        wait_lvl("bp_cs2", 0, 1'b0, 20, t0);
        mode0 = 1'b0;
        wait_lvl("bp_idle", 2, 1'b0, 200, t3);
        chk("bp_ovr_set", 32'(ovr0), 1);
        chk("bp_valid_held", 32'(if0.sample_valid), 1);
        chk("bp_data_held", 32'(if0.sample_data), 32'h333111);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("bp_ovr_clr", 32'(ovr0), 0);
        @(posedge clk); #1 if0.sample_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", 32'(if0.sample_valid), 0);
        chk("bp_all_seen", 32'(exp0.size()), 0);

        // Averaging (AVG_LOG2=2)
        fA_q.push_back(32'h0010_0001);
        fA_q.push_back(32'h0020_0002);
        fA_q.push_back(32'h0030_0003);
        fA_q.push_back(32'h0041_0004);
        expA.push_back({12'h028, 12'h002});
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        wait_lvl("avg_idle", 3, 1'b0, 400, t3);
        repeat (100) @(negedge clk);
        chk("avg_frames", 32'(nfA), 4);
        chk("avg_results", 32'(accA), 1);

        // Ignored start (CLK_DIV=1, NUM_CH=1)
        fF_q.push_back(16'h0FED);
        expF.push_back(12'hFED);
        startF = 1'b1;
        wait_lvl("fs_cs_fall", 4, 1'b0, 5, t0);
        startF = 1'b0;
        repeat (5) @(negedge clk);
        startF = 1'b1;
        @(negedge clk);
        startF = 1'b0;
        wait_lvl("fs_cs_rise", 4, 1'b1, 60, t1);
        startF = 1'b1;
        @(negedge clk);
        startF = 1'b0;
        chk("fs_cs_low_len", 32'(t1 - t0), 33);
        repeat (60) @(negedge clk);
        chk("fs_frames", 32'(nfF), 1);
        chk("fs_results", 32'(accF), 1);
        chk("fs_busy", 32'(busyF), 0);

        // Reset mid-frame (held result pending)
        @(posedge clk); #1 if0.sample_ready = 1'b0;
        f0_q.push_back(32'h0666_0555);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_lvl("rm_valid", 1, 1'b1, 200, t2);
        wait_lvl("rm_idle", 2, 1'b0, 20, t3);
        f0_q.push_back(32'h0777_0777);
        ts = cyc;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (19) @(negedge clk);
        chk("rm_pre_cs", 32'(cs0), 0);
        chk("rm_pre_sclk", 32'(sclk0), 0);
        chk("rm_pre_valid", 32'(if0.sample_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_cs", 32'(cs0), 1);
        chk("rm_sclk", 32'(sclk0), 1);
        chk("rm_valid", 32'(if0.sample_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ncs = 0;
        repeat (150) begin
            @(negedge clk);
            if (cs0 == 1'b0) ncs++;
        end
        chk("rm_stays_idle_cs", 32'(ncs), 0);
        chk("rm_stays_idle_busy", 32'(busy0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
